// File: rtl/ff_modes_pkg.sv
// Mode encodings shared by the universal flip-flop bank,
// its per-bit cell and the bus interface.
package ff_modes_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } ff_mode_e;

endpackage

// File: rtl/multi_mode_ff_bank_if.sv
// Control/status bundle of the multi-mode flip-flop bank.
// master drives controls, slave is the bank.
interface multi_mode_ff_bank_if
  import ff_modes_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             en;
  ff_mode_e         mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] changed;
  logic [WIDTH-1:0] sr_err;
  logic [CNT_W-1:0] act_cnt;

  modport master (
    output en, mode, a, b, load, load_val, err_clr,
    input  q, qn, changed, sr_err, act_cnt
  );

  modport slave (
    input  en, mode, a, b, load, load_val, err_clr,
    output q, qn, changed, sr_err, act_cnt
  );
endinterface

// File: rtl/ff_cell.sv
// One universal flip-flop bit (SR/JK/D/T) with load and enable.
// q_next is exported so the bank can derive change/activity.
module ff_cell
  import ff_modes_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  ff_mode_e mode,
  input  logic     a,
  input  logic     b,
  input  logic     load,
  input  logic     load_val,
  output logic     q,
  output logic     q_next,
  output logic     illegal
);

  always_comb begin
    q_next  = q;
    illegal = 1'b0;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      unique case (mode)
        MODE_SR: begin
          unique case ({a, b})
            2'b01:   q_next = 1'b0;
            2'b10:   q_next = 1'b1;
            2'b11:   illegal = 1'b1;
            default: q_next = q;
          endcase
        end
        MODE_JK: begin
          unique case ({a, b})
            2'b01:   q_next = 1'b0;
            2'b10:   q_next = 1'b1;
            2'b11:   q_next = ~q;
            default: q_next = q;
          endcase
        end
        MODE_D:  q_next = a;
        MODE_T:  q_next = a ? ~q : q;
        default: q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_BIT;
    else     q <= q_next;
  end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-bit bank of universal flip-flops with sticky illegal-SR
// flags, a change mask and a saturating activity counter.
module multi_mode_ff_bank
  import ff_modes_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input logic           clk,
  input logic           rst,
  multi_mode_ff_bank_if.slave bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal;
  logic [WIDTH-1:0] changed;
  logic [WIDTH-1:0] sr_err;
  logic [CNT_W-1:0] act_cnt;
  logic [WIDTH-1:0] diff;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RST_BIT (RESET_VAL[i])
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .mode     (bus.mode),
      .a        (bus.a[i]),
      .b        (bus.b[i]),
      .load     (bus.load),
      .load_val (bus.load_val[i]),
      .q        (q[i]),
      .q_next   (q_next[i]),
      .illegal  (illegal[i])
    );
  end

  assign diff = q_next ^ q;

  // A fresh illegal SR pair beats err_clr on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed <= '0;
      sr_err  <= '0;
      act_cnt <= '0;
    end else begin
      changed <= diff;
      sr_err  <= (sr_err & ~{WIDTH{bus.err_clr}}) | illegal;
      if (|diff && act_cnt != {CNT_W{1'b1}})
        act_cnt <= act_cnt + 1'b1;
    end
  end

  assign bus.q       = q;
  assign bus.qn      = ~q;
  assign bus.changed = changed;
  assign bus.sr_err  = sr_err;
  assign bus.act_cnt = act_cnt;

endmodule
